// File: rtl/sr_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sr_config_ctrl
// Description : Multi-channel serial configuration controller for on-chip
//               shift-register chains. On start it latches NCH words of WIDTH
//               bits, shifts them out bit-serially on a divided sr_clk, pulses
//               sr_load with one sr_clk pulse inside it, and captures the old
//               chain contents returned on sr_dout into rb_data.
// Ports       : clk, rst      - system clock, asynchronous active-high reset
//               start         - sequence request, sampled only when idle
//               din, ch_en    - channel words (c at din[c*WIDTH +: WIDTH]) and
//                               channel enable mask, latched at start
//               busy, done    - sequence in progress / end-of-sequence pulse
//               sr_clk, sr_din, sr_load - registered chain drive
//               sr_dout       - serial data returned from the chain tails
//               rb_data       - readback words, same layout as din
// Revision    : 1.0 - initial release
// ============================================================================
module sr_config_ctrl #(
    parameter int WIDTH     = 170,
    parameter int NCH       = 4,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [NCH-1:0]         ch_en,
    output logic                   busy,
    output logic                   done,
    output logic                   sr_clk,
    output logic [NCH-1:0]         sr_din,
    output logic                   sr_load,
    input  logic [NCH-1:0]         sr_dout,
    output logic [NCH*WIDTH-1:0]   rb_data
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_SHIFT = 3'd2,
        S_LOAD  = 3'd3,
        S_POST  = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [DW-1:0]          div_cnt, div_nxt;
    logic                   phase, phase_nxt;      // 0: sr_clk low half, 1: high half
    logic [BW-1:0]          bit_cnt, bit_nxt;
    logic [NCH*WIDTH-1:0]   shadow, shadow_nxt;
    logic [NCH-1:0]         en_sh, en_nxt;
    logic                   busy_nxt, done_nxt, sr_clk_nxt, sr_load_nxt;
    logic [NCH-1:0]         sr_din_nxt;
    logic [NCH*WIDTH-1:0]   rb_nxt;
    logic                   tick;

    // Position inside a channel word of sequence bit k; the same mapping is
    // used for transmit and for readback so a loopback returns the word intact.
    function automatic int bit_index(input int k);
        return (MSB_FIRST != 0) ? (WIDTH - 1 - k) : k;
    endfunction

    // Sequence bit k of every channel, zero for disabled channels.
    function automatic logic [NCH-1:0] seq_bits(input logic [NCH*WIDTH-1:0] word,
                                                input logic [NCH-1:0]       en,
                                                input int                   k);
        logic [NCH-1:0] b;
        b = '0;
        for (int c = 0; c < NCH; c++) begin
            b[c] = en[c] & word[c*WIDTH + bit_index(k)];
        end
        return b;
    endfunction

    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        state_nxt   = state;
        div_nxt     = tick ? '0 : div_cnt + DW'(1);
        phase_nxt   = phase;
        bit_nxt     = bit_cnt;
        shadow_nxt  = shadow;
        en_nxt      = en_sh;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        sr_clk_nxt  = sr_clk;
        sr_din_nxt  = sr_din;
        sr_load_nxt = sr_load;
        rb_nxt      = rb_data;

        case (state)
            S_IDLE: begin
                div_nxt   = '0;
                phase_nxt = 1'b0;
                busy_nxt  = 1'b0;
                if (start) begin
                    shadow_nxt = din;
                    en_nxt     = ch_en;
                    bit_nxt    = '0;
                    busy_nxt   = 1'b1;
                    // Present bit 0 straight from din so it has the whole PRE
                    // period as setup time before the first rising sr_clk.
                    sr_din_nxt = seq_bits(din, ch_en, 0);
                    state_nxt  = S_PRE;
                end
            end

            S_PRE: begin
                if (tick) begin
                    phase_nxt = 1'b0;
                    state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (tick) begin
                    if (!phase) begin
                        // Rising sr_clk: the chain tail still shows the bit
                        // that this edge is about to shift out.
                        sr_clk_nxt = 1'b1;
                        phase_nxt  = 1'b1;
                        for (int c = 0; c < NCH; c++) begin
                            if (en_sh[c]) begin
                                rb_nxt[c*WIDTH + bit_index(int'(bit_cnt))] = sr_dout[c];
                            end
                        end
                    end else begin
                        sr_clk_nxt = 1'b0;
                        phase_nxt  = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            sr_din_nxt  = '0;
                            sr_load_nxt = 1'b1;
                            state_nxt   = S_LOAD;
                        end else begin
                            bit_nxt    = bit_cnt + BW'(1);
                            sr_din_nxt = seq_bits(shadow, en_sh, int'(bit_cnt) + 1);
                        end
                    end
                end
            end

            S_LOAD: begin
                if (tick) begin
                    if (!phase) begin
                        sr_clk_nxt = 1'b1;
                        phase_nxt  = 1'b1;
                    end else begin
                        sr_clk_nxt  = 1'b0;
                        sr_load_nxt = 1'b0;
                        phase_nxt   = 1'b0;
                        state_nxt   = S_POST;
                    end
                end
            end

            S_POST: begin
                // The done cycle is still spent in POST so a start coinciding
                // with done is ignored; busy drops together with the return
                // to IDLE.
                if (done) begin
                    busy_nxt  = 1'b0;
                    div_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (tick) begin
                    done_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            shadow  <= '0;
            en_sh   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sr_clk  <= 1'b0;
            sr_din  <= '0;
            sr_load <= 1'b0;
            rb_data <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_nxt;
            shadow  <= shadow_nxt;
            en_sh   <= en_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            sr_clk  <= sr_clk_nxt;
            sr_din  <= sr_din_nxt;
            sr_load <= sr_load_nxt;
            rb_data <= rb_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_config_ctrl
// Description : Scoreboard bench for sr_config_ctrl. Two instances:
//               A: WIDTH=8, NCH=4, CLK_DIV=3, LSB first
//               B: WIDTH=8, NCH=4, CLK_DIV=1, MSB first (back-to-back starts)
//               Each drives a chain model (8-bit SR per channel, shifting on
//               rising sr_clk, latching its contents while sr_load is high).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_config_ctrl;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int DA    = 3;
    localparam int DB    = 1;
    localparam int LAT_A = (2*W + 4) * DA;
    localparam int LAT_B = (2*W + 4) * DB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic          start_a = 1'b0;
    logic [31:0]   din_a   = '0;
    logic [3:0]    en_a    = '0;
    logic          busy_a, done_a, sr_clk_a, sr_load_a;
    logic [3:0]    sr_din_a, sr_dout_a;
    logic [31:0]   rb_a;

    sr_config_ctrl #(.WIDTH(W), .NCH(N), .CLK_DIV(DA), .MSB_FIRST(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .din(din_a), .ch_en(en_a),
        .busy(busy_a), .done(done_a), .sr_clk(sr_clk_a), .sr_din(sr_din_a),
        .sr_load(sr_load_a), .sr_dout(sr_dout_a), .rb_data(rb_a)
    );

    // ---------------- instance B ----------------
    logic          start_b = 1'b0;
    logic [31:0]   din_b   = '0;
    logic [3:0]    en_b    = '0;
    logic          busy_b, done_b, sr_clk_b, sr_load_b;
    logic [3:0]    sr_din_b, sr_dout_b;
    logic [31:0]   rb_b;

    sr_config_ctrl #(.WIDTH(W), .NCH(N), .CLK_DIV(DB), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .din(din_b), .ch_en(en_b),
        .busy(busy_b), .done(done_b), .sr_clk(sr_clk_b), .sr_din(sr_din_b),
        .sr_load(sr_load_b), .sr_dout(sr_dout_b), .rb_data(rb_b)
    );

    // ---------------- chain models ----------------
    logic [31:0] chain_a, cfg_a, chain_b, cfg_b;
    int          edges_a, edges_b;

    always @(posedge sr_clk_a or posedge rst) begin
        if (rst) begin
            chain_a <= '0; cfg_a <= '0; edges_a <= 0;
        end else begin
            edges_a <= edges_a + 1;
            if (sr_load_a) cfg_a <= chain_a;
            else for (int c = 0; c < N; c++) chain_a[c*W +: W] <= {chain_a[c*W +: W-1], sr_din_a[c]};
        end
    end
    assign sr_dout_a = {chain_a[31], chain_a[23], chain_a[15], chain_a[7]};

    always @(posedge sr_clk_b or posedge rst) begin
        if (rst) begin
            chain_b <= '0; cfg_b <= '0; edges_b <= 0;
        end else begin
            edges_b <= edges_b + 1;
            if (sr_load_b) cfg_b <= chain_b;
            else for (int c = 0; c < N; c++) chain_b[c*W +: W] <= {chain_b[c*W +: W-1], sr_din_b[c]};
        end
    end
    assign sr_dout_b = {chain_b[31], chain_b[23], chain_b[15], chain_b[7]};

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rb;
        logic [31:0] cfg;
        int          done_edge;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Latency: done is seen here after clock edge number cyc; a flop fed by
    // done captures it one edge later, i.e. (2*WIDTH+4)*CLK_DIV+1 edges after
    // the start-sampling edge.
    int mark_a = 0;
    always @(negedge clk) begin
        if (rst) begin
            mark_a = 0;
        end else if (done_a) begin
            if (q_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a_unexpected_done: got done=1, expected no done (t=%0t)", $time);
            end else begin
                ea = q_a.pop_front();
                check("a_rb_data",   rb_a,  ea.rb);
                check("a_chain_cfg", cfg_a, ea.cfg);
                check("a_latency",   32'(cyc), 32'(ea.done_edge));
                check("a_sr_clk_edges", 32'(edges_a - mark_a), 32'(W + 1));
                mark_a = edges_a;
            end
        end
    end

    int   mark_b = 0;
    bit   b2b = 1'b0;
    int   low_run = 0;
    int   rises = 0;
    logic busy_b_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mark_b = 0;
        end else if (done_b) begin
            if (q_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected_done: got done=1, expected no done (t=%0t)", $time);
            end else begin
                eb = q_b.pop_front();
                check("b_rb_data",   rb_b,  eb.rb);
                check("b_chain_cfg", cfg_b, eb.cfg);
                check("b_latency",   32'(cyc), 32'(eb.done_edge));
                check("b_sr_clk_edges", 32'(edges_b - mark_b), 32'(W + 1));
                mark_b = edges_b;
            end
        end
        if (busy_b) begin
            if (!busy_b_prev && b2b) begin
                if (rises > 0) check("b_busy_gap_cycles", 32'(low_run), 32'd1);
                rises++;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        busy_b_prev = busy_b;
    end

    // ---------------- stimulus ----------------
    task automatic wait_drain_a();
        int t;
        t = 0;
        while (q_a.size() != 0 && t < 1000) begin @(negedge clk); t++; end
        if (q_a.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL a_timeout: got %0d pending, expected 0", q_a.size());
            q_a.delete();
        end
    endtask

    task automatic wait_drain_b();
        int t;
        t = 0;
        while (q_b.size() != 0 && t < 1000) begin @(negedge clk); t++; end
        if (q_b.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL b_timeout: got %0d pending, expected 0", q_b.size());
            q_b.delete();
        end
    endtask

    task automatic write_a(input logic [31:0] d, input logic [3:0] en,
                           input logic [31:0] rb_exp, input logic [31:0] cfg_exp);
        exp_t e;
        @(negedge clk);
        din_a = d; en_a = en; start_a = 1'b1;
        e.rb = rb_exp; e.cfg = cfg_exp; e.done_edge = cyc + 1 + LAT_A;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        wait_drain_a();
    endtask

    task automatic write_b(input logic [31:0] d, input logic [3:0] en,
                           input logic [31:0] rb_exp, input logic [31:0] cfg_exp);
        exp_t e;
        @(negedge clk);
        din_b = d; en_b = en; start_b = 1'b1;
        e.rb = rb_exp; e.cfg = cfg_exp; e.done_edge = cyc + 1 + LAT_B;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        wait_drain_b();
    endtask

    // Instance A vectors (LSB first: the loaded chain holds each byte
    // bit-reversed; readback returns the word written previously).
    localparam logic [31:0] VA_DIN [4] = '{32'h12F0_8101, 32'hA53C_7E96, 32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [3:0]  VA_EN  [4] = '{4'hF,          4'hF,          4'b0101,       4'hF};
    localparam logic [31:0] VA_RB  [4] = '{32'h0000_0000, 32'h12F0_8101, 32'h123C_8196, 32'h00FF_00FF};
    localparam logic [31:0] VA_CFG [4] = '{32'h480F_8180, 32'hA53C_7E69, 32'h00FF_00FF, 32'h0000_0000};

    initial begin
        exp_t e;
        int   s;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("a_reset_outputs", 32'({busy_a, done_a, sr_clk_a, sr_load_a, sr_din_a}), 32'd0);
        check("a_reset_rb",      rb_a, 32'd0);
        check("b_reset_outputs", 32'({busy_b, done_b, sr_clk_b, sr_load_b, sr_din_b}), 32'd0);
        check("b_reset_rb",      rb_b, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) write_a(VA_DIN[i], VA_EN[i], VA_RB[i], VA_CFG[i]);

        // Abort mid-shift with reset: everything returns to zero at once.
        @(negedge clk);
        din_a = 32'hDEAD_BEEF; en_a = 4'hF; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("a_midrun_reset_outputs", 32'({busy_a, done_a, sr_clk_a, sr_load_a, sr_din_a}), 32'd0);
        check("a_midrun_reset_rb",      rb_a, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("a_no_sr_clk_after_reset", 32'(edges_a), 32'd0);

        write_a(32'h0000_0001, 4'hF, 32'h0000_0000, 32'h0000_0080);

        // Instance B: MSB first, A5 goes out as 1,0,1,0,0,1,0,1 so the chain
        // holds A5 unchanged.
        write_b(32'h0000_00A5, 4'hF, 32'h0000_0000, 32'h0000_00A5);

        // Start held high: three back-to-back sequences spaced LAT_B+2 edges.
        @(negedge clk);
        din_b = 32'h1122_3344; en_b = 4'hF; start_b = 1'b1; b2b = 1'b1; rises = 0;
        s = cyc + 1;
        e.cfg = 32'h1122_3344;
        e.rb = 32'h0000_00A5; e.done_edge = s + LAT_B;              q_b.push_back(e);
        e.rb = 32'h1122_3344; e.done_edge = s + LAT_B + (LAT_B + 2); q_b.push_back(e);
        e.rb = 32'h1122_3344; e.done_edge = s + LAT_B + 2*(LAT_B + 2); q_b.push_back(e);
        repeat (45) @(negedge clk);
        start_b = 1'b0;
        wait_drain_b();
        repeat (4) @(negedge clk);
        b2b = 1'b0;
        check("b_busy_rises", 32'(rises), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
